// File: rtl/sort_pkg.sv
// Shared definitions for the sort stream driver and sorting_top users:
// default geometry and the driver state encoding.
package sort_pkg;

  localparam int DEF_N       = 8;
  localparam int DEF_L       = 4;
  localparam int DEF_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_RD_REQ  = 3'd4,
    S_RD_CAP  = 3'd5,
    S_OUT     = 3'd6
  } sort_state_t;

endpackage

// File: rtl/sort_stream_driver.sv
// Streams a block of D words into the sorter memory, starts the sort, and
// drains the sorted block downstream one word per three cycles.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   LOAD      | accept upstream words, write them at RAddr = cnt
//   START     | one-cycle start pulse, timeout counter cleared
//   WAIT_LO   | wait for done low (ignore stale done of previous block)
//   WAIT_HI   | wait for done high, then begin reading at address 0
//   RD_REQ    | Rd strobe at RAddr = cnt
//   RD_CAP    | capture DataOut into out_data, flag last word
//   OUT       | present word until out_ready
module sort_stream_driver
  import sort_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int L       = DEF_L,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         WrInit,
  output logic         Rd,
  output logic [L-1:0] RAddr,
  output logic [N-1:0] DataIn,
  output logic         start,
  input  logic [N-1:0] DataOut,
  input  logic         done,
  output logic         busy,
  output logic         err
);

  localparam int          TW       = $clog2(TIMEOUT + 1);
  localparam logic [L-1:0] LAST_IDX = '1;
  localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);

  sort_state_t   state;
  logic [L-1:0]  cnt;
  logic [TW-1:0] tmo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOAD;
      cnt      <= '0;
      tmo      <= '0;
      err      <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) state <= S_START;
          end
        end
        S_START: begin
          tmo   <= '0;
          state <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (tmo == TMO_END) begin
            err   <= 1'b1;
            cnt   <= '0;
            state <= S_LOAD;
          end else begin
            tmo <= tmo + 1'b1;
            if (!done) state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          if (tmo == TMO_END) begin
            err   <= 1'b1;
            cnt   <= '0;
            state <= S_LOAD;
          end else begin
            tmo <= tmo + 1'b1;
            if (done) begin
              cnt   <= '0;
              state <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: state <= S_RD_CAP;
        S_RD_CAP: begin
          out_data <= DataOut;
          out_last <= (cnt == LAST_IDX);
          state    <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            if (out_last) begin
              cnt   <= '0;
              state <= S_LOAD;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_RD_REQ;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Strobes are gated by rst so the interface is quiet during the reset cycle.
  assign in_ready  = !rst && (state == S_LOAD);
  assign WrInit    = in_ready && in_valid;
  assign Rd        = !rst && (state == S_RD_REQ);
  assign start     = !rst && (state == S_START);
  assign out_valid = !rst && (state == S_OUT);
  assign busy      = !rst && (state != S_LOAD);
  assign RAddr     = (in_ready || Rd) ? cnt : '0;
  assign DataIn    = WrInit ? in_data : '0;

endmodule

// File: tb/tb_sort_stream_driver.sv
// Scoreboard bench for sort_stream_driver with a behavioural sorter memory.
module tb_sort_stream_driver;

  localparam int N   = 8;
  localparam int L   = 4;
  localparam int D   = 16;
  localparam int TMO = 64;

  typedef struct packed {
    logic [N-1:0] data;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] out_data;
  logic         out_last;
  logic         WrInit, Rd, start, busy, err;
  logic [L-1:0] RAddr;
  logic [N-1:0] DataIn;
  logic [N-1:0] DataOut = '0;
  logic         done = 1'b0;

  exp_t         expq[$];
  logic [N-1:0] blk[$];
  logic [N-1:0] mem[D];
  logic [N-1:0] srt[D];
  logic [N-1:0] tbl[D] = '{8'd9, 8'd3, 8'd15, 8'd0, 8'd7, 8'd12, 8'd1, 8'd14,
                           8'd5, 8'd10, 8'd2, 8'd13, 8'd6, 8'd11, 8'd4, 8'd8};

  int n_checks = 0, n_err = 0;
  int wr_cnt = 0, st_cnt = 0, acc_cnt = 0, last_cnt = 0, word_idx = 0;
  int exp_waddr = 0, exp_raddr = 0, stall_left = 0;
  int stale_hold = 3, sort_lat = 10;
  bit stall_en = 0, nodone = 0, saw_lo = 0, saw_hi = 0, held_v = 0;
  logic [N-1:0] hd;
  logic         hl;

  always #5 clk = ~clk;

  sort_stream_driver #(.N(N), .L(L), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .WrInit(WrInit), .Rd(Rd), .RAddr(RAddr), .DataIn(DataIn),
    .start(start), .DataOut(DataOut), .done(done), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Sorter model: drops a stale done after a hold, then sorts and raises done.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!rst && start) begin
        if (done) begin
          repeat (stale_hold) @(posedge clk);
          #1;
        end
        done = 1'b0;
        if (!nodone) begin
          repeat (sort_lat) @(posedge clk);
          #1;
          for (int i = 0; i < D; i++) srt[i] = mem[i];
          for (int i = 0; i < D - 1; i++)
            for (int j = 0; j < D - 1 - i; j++)
              if (srt[j] > srt[j+1]) begin
                logic [N-1:0] t;
                t = srt[j]; srt[j] = srt[j+1]; srt[j+1] = t;
              end
          done = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (Rd) DataOut = srt[RAddr];
  end

  // Sorter-side interface monitor.
  always @(negedge clk) begin
    if (rst) begin
      exp_waddr = 0;
    end else begin
      chk("excl", 32'(int'(WrInit) + int'(Rd) + int'(start) <= 1), 1);
      if (WrInit) begin
        chk("waddr", 32'(RAddr), exp_waddr);
        chk("wdata", 32'(DataIn), 32'(in_data));
        mem[RAddr] = DataIn;
        exp_waddr++;
        wr_cnt++;
      end
      if (Rd) begin
        chk("rd_after_done", 32'(saw_hi), 1);
        chk("raddr", 32'(RAddr), exp_raddr);
        exp_raddr++;
      end
      if (start) begin
        st_cnt++;
        exp_waddr = 0;
        exp_raddr = 0;
        saw_lo = 0;
        saw_hi = 0;
      end else begin
        if (!done) saw_lo = 1;
        if (saw_lo && done) saw_hi = 1;
      end
    end
  end

  // Downstream consumer: pops the scoreboard on every accepted word.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (out_ready) begin
        if (expq.size() == 0) begin
          chk("spurious_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
        if (out_last) last_cnt++;
        acc_cnt++;
        word_idx++;
        held_v = 0;
      end else begin
        if (held_v) begin
          chk("hold_data", 32'(out_data), 32'(hd));
          chk("hold_last", 32'(out_last), 32'(hl));
        end
        chk("rd_in_stall", 32'(Rd), 0);
        hd = out_data;
        hl = out_last;
        held_v = 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_en && word_idx == 5 && out_valid && stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic load_words(input int n, input bit gap, input bit use_tbl, input bit push);
    logic [N-1:0] v;
    int g;
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      v = use_tbl ? tbl[i] : N'($urandom_range(0, 255));
      in_valid = 1'b1;
      in_data  = v;
      g = 0;
      while (!in_ready && g < 200) begin
        @(posedge clk); #1;
        g++;
      end
      if (g >= 200) chk("load_timeout", 32'(g), 0);
      if (push) blk.push_back(v);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push && n == D) begin
      blk.sort();
      for (int i = 0; i < D; i++) begin
        exp_t e;
        e.data = blk[i];
        e.last = (i == D - 1);
        expq.push_back(e);
      end
    end
    blk.delete();
  endtask

  task automatic wait_drain(input int target);
    int g = 0;
    while (acc_cnt < target && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("drain_count", 32'(acc_cnt), 32'(target));
    chk("scoreboard_empty", 32'(expq.size()), 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_wrinit", 32'(WrInit), 0);
    chk("rst_rd", 32'(Rd), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_raddr", 32'(RAddr), 0);
    chk("rst_datain", 32'(DataIn), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_in_ready", 32'(in_ready), 1);
    chk("post_out_data", 32'(out_data), 0);
    chk("post_out_last", 32'(out_last), 0);
    chk("post_err", 32'(err), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  task automatic clear_counts();
    wr_cnt = 0; st_cnt = 0; acc_cnt = 0; last_cnt = 0; word_idx = 0;
  endtask

  initial begin
    int g, n;
    bit seen_valid;

    reset_pulse();

    // Table block: ascending drain, one start, last only on word 16.
    clear_counts();
    load_words(D, 0, 1, 1);
    wait_drain(D);
    chk("b1_writes", 32'(wr_cnt), D);
    chk("b1_starts", 32'(st_cnt), 1);
    chk("b1_lasts", 32'(last_cnt), 1);

    // Gapped load, stalled drain at word 6.
    clear_counts();
    stall_en = 1; stall_left = 5;
    load_words(D, 1, 0, 1);
    wait_drain(D);
    chk("b2_writes", 32'(wr_cnt), D);
    chk("b2_stall_done", 32'(stall_left), 0);
    stall_en = 0;

    // done still high from the previous block.
    clear_counts();
    chk("b3_stale_done", 32'(done), 1);
    stale_hold = 6;
    load_words(D, 0, 0, 1);
    wait_drain(D);
    chk("b3_starts", 32'(st_cnt), 1);
    stale_hold = 3;

    // done never rises: timeout.
    clear_counts();
    nodone = 1;
    load_words(D, 0, 0, 0);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!start && g < 100);
    chk("tmo_start_seen", 32'(start), 1);
    n = 0;
    while (!err && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 32) chk("tmo_err_early", 32'(err), 0);
    end
    chk("tmo_latency", 32'(n >= 64 && n <= 65), 1);
    chk("tmo_in_ready", 32'(in_ready), 1);
    chk("tmo_busy", 32'(busy), 0);
    nodone = 0;

    // Still functional while err is set.
    clear_counts();
    load_words(D, 0, 0, 1);
    wait_drain(D);
    chk("err_sticky", 32'(err), 1);

    // Reset in the middle of a load.
    clear_counts();
    load_words(10, 0, 0, 0);
    chk("midload_writes", 32'(wr_cnt), 10);
    reset_pulse();
    clear_counts();
    load_words(D, 0, 0, 1);
    wait_drain(D);
    chk("after_rst_writes", 32'(wr_cnt), D);

    // Reset in the middle of a drain.
    clear_counts();
    load_words(D, 0, 0, 1);
    g = 0;
    while (acc_cnt < 4 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("middrain_reached", 32'(acc_cnt), 4);
    reset_pulse();
    expq.delete();
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1;
    end
    chk("no_residual", 32'(seen_valid), 0);
    clear_counts();
    load_words(D, 0, 0, 1);
    wait_drain(D);
    chk("final_lasts", 32'(last_cnt), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
